// File: rtl/doodle_pkg.sv
// Shared play-field geometry and controller state encoding.
// Latency: n/a (constants only).
// Backpressure: n/a.
package doodle_pkg;
  localparam int SCREEN_WIDTH  = 400;
  localparam int SCREEN_HEIGHT = 700;
  localparam int BLOCK_WIDTH   = 40;
  // Platform height is consumed by the renderer, not by the scroll logic.
  localparam int BLOCK_HEIGHT  = 5;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_SCROLL   = 2'd1;
  localparam logic [1:0] S_SPAWN    = 2'd2;
  localparam logic [1:0] S_GAMEOVER = 2'd3;
endpackage

// File: rtl/block_x_lfsr.sv
// Free-running 16-bit Fibonacci LFSR folded into a legal platform X position.
// Latency: xPos reflects the current LFSR register (combinational fold), LFSR steps every clk.
// Backpressure: none; consumers sample xPos whenever they need a new value.
module block_x_lfsr #(
  parameter int SCREEN_WIDTH = doodle_pkg::SCREEN_WIDTH,
  parameter int BLOCK_WIDTH  = doodle_pkg::BLOCK_WIDTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] seed,
  output logic [31:0] xPos
);
  // Number of legal left-edge positions; values at or above it wrap back once.
  localparam logic [9:0] X_SPAN = 10'(SCREEN_WIDTH - BLOCK_WIDTH + 1);

  logic [15:0] lfsr;
  logic        feedback;
  logic [9:0]  xRaw;

  assign feedback = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  // Shift register advances every cycle, taps 16,14,13,11.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr <= seed;
    else       lfsr <= {lfsr[14:0], feedback};
  end

  // Fold the 9-bit raw value (0..511) into 0..SCREEN_WIDTH-BLOCK_WIDTH.
  always_comb begin
    xRaw = {1'b0, lfsr[8:0]};
    if (xRaw >= X_SPAN) xRaw = xRaw - X_SPAN;
  end

  assign xPos = {22'd0, xRaw};
endmodule

// File: rtl/view_scroll_controller.sv
// Camera scroll sequencer: scrolls minY in frame-paced steps, then requests new platforms.
// Latency: all outputs registered; state changes one clk after the sampling frameTick/spawnAck.
// Backpressure: spawnReq/spawnX/spawnY hold until spawnAck; acks outside SPAWN are ignored.
module view_scroll_controller
  import doodle_pkg::*;
#(
  parameter int          SCREEN_WIDTH    = doodle_pkg::SCREEN_WIDTH,
  parameter int          SCREEN_HEIGHT   = doodle_pkg::SCREEN_HEIGHT,
  parameter int          BLOCK_WIDTH     = doodle_pkg::BLOCK_WIDTH,
  parameter int          SCROLL_STEP     = 175,
  parameter int          SCROLL_SPEED    = 25,
  parameter int          BLOCKS_PER_STEP = 3,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frameTick,
  input  logic [31:0] doodleY,
  input  logic        spawnAck,
  output logic [31:0] minY,
  output logic        scrolling,
  output logic        minYCrossed,
  output logic        newView,
  output logic        spawnReq,
  output logic [31:0] spawnX,
  output logic [31:0] spawnY
);
  localparam logic [31:0] HALF_H    = 32'(SCREEN_HEIGHT >> 1);
  localparam logic [31:0] STEP_C    = 32'(SCROLL_STEP);
  localparam logic [31:0] SPEED_C   = 32'(SCROLL_SPEED);
  // Bottom of the freshly revealed strip, relative to minY after the scroll.
  localparam logic [31:0] SPAWN_OFS = 32'(SCREEN_HEIGHT - SCROLL_STEP);
  localparam logic [31:0] GAP       = 32'(SCROLL_STEP / BLOCKS_PER_STEP);
  localparam logic [31:0] LAST_IDX  = 32'(BLOCKS_PER_STEP - 1);

  logic [1:0]  state;
  logic [31:0] remaining;
  logic [31:0] idx;
  logic [31:0] step;
  logic [31:0] xPos;

  block_x_lfsr #(
    .SCREEN_WIDTH(SCREEN_WIDTH),
    .BLOCK_WIDTH (BLOCK_WIDTH)
  ) uXLfsr (
    .clk  (clk),
    .reset(reset),
    .seed (LFSR_SEED),
    .xPos (xPos)
  );

  // Per-frame scroll increment, clipped so the last frame lands exactly on the step total.
  always_comb step = (remaining < SPEED_C) ? remaining : SPEED_C;

  // Main sequencer: IDLE -> SCROLL -> SPAWN -> IDLE, with GAMEOVER as a sink.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      minY        <= '0;
      remaining   <= '0;
      idx         <= '0;
      scrolling   <= 1'b0;
      minYCrossed <= 1'b0;
      newView     <= 1'b0;
      spawnReq    <= 1'b0;
      spawnX      <= '0;
      spawnY      <= '0;
    end else begin
      newView <= 1'b0;
      case (state)
        S_IDLE: begin
          if (frameTick) begin
            if (doodleY < minY) begin
              state       <= S_GAMEOVER;
              minYCrossed <= 1'b1;
            end else if (doodleY > minY + HALF_H) begin
              state     <= S_SCROLL;
              remaining <= STEP_C;
              scrolling <= 1'b1;
            end
          end
        end
        S_SCROLL: begin
          if (frameTick) begin
            if (doodleY < minY) begin
              // Falling out of view aborts the scroll with minY left where it is.
              state       <= S_GAMEOVER;
              minYCrossed <= 1'b1;
              scrolling   <= 1'b0;
            end else begin
              minY      <= minY + step;
              remaining <= remaining - step;
              if (remaining == step) begin
                state     <= S_SPAWN;
                scrolling <= 1'b0;
                idx       <= '0;
                spawnReq  <= 1'b1;
                spawnX    <= xPos;
                spawnY    <= minY + step + SPAWN_OFS;
              end
            end
          end
        end
        S_SPAWN: begin
          // minY is frozen here, so any fall-out is caught on the next IDLE tick.
          if (spawnAck) begin
            if (idx == LAST_IDX) begin
              state    <= S_IDLE;
              idx      <= '0;
              spawnReq <= 1'b0;
              newView  <= 1'b1;
            end else begin
              idx    <= idx + 32'd1;
              spawnX <= xPos;
              spawnY <= minY + SPAWN_OFS + (idx + 32'd1) * GAP;
            end
          end
        end
        default: begin
          // GAMEOVER: everything frozen until reset.
        end
      endcase
    end
  end
endmodule
